// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset PC, NOP encoding, primary opcodes,
// fetch FSM states and the fetch queue entry layout.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetchEntry_t;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {instr, pc} queue (head = IF/ID register, skid behind it); head data reads as
// NOP/0 when empty. Push/pop take effect on the same edge; flush wins over both.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fetchEntry_t pushEntry,
  input  logic        pop,
  input  logic        flush,
  output logic        headVld,
  output logic        skidVld,
  output fetchEntry_t headEntry
);

  fetchEntry_t skidEntry;
  logic        popEff;

  assign popEff = pop & headVld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headVld   <= 1'b0;
      skidVld   <= 1'b0;
      headEntry <= '0;
      skidEntry <= '0;
    end else if (flush) begin
      headVld   <= 1'b0;
      skidVld   <= 1'b0;
      headEntry <= '0;
      skidEntry <= '0;
    end else begin
      case ({popEff, push})
        2'b10: begin
          if (skidVld) begin
            headEntry <= skidEntry;
            skidVld   <= 1'b0;
            skidEntry <= '0;
          end else begin
            headVld   <= 1'b0;
            headEntry <= '0;
          end
        end
        2'b01: begin
          if (!headVld) begin
            headVld   <= 1'b1;
            headEntry <= pushEntry;
          end else begin
            skidVld   <= 1'b1;
            skidEntry <= pushEntry;
          end
        end
        2'b11: begin
          // Keep program order: the older skid word advances before the new one lands.
          if (skidVld) begin
            headEntry <= skidEntry;
            skidEntry <= pushEntry;
          end else begin
            headEntry <= pushEntry;
          end
        end
        default: ;
      endcase
    end
  end

  noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && skidVld && !popEff));

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC, single-outstanding imem request, 2-entry IF/ID queue.
// 1-cycle memory gives req->instr_valid in 2 cycles; id_stall holds the head and fetch parks in HOLD.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
)
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode
);

  fetchState_t state, stateNxt;
  logic [31:0] pc, pcNxt;
  logic        discard, discardNxt;
  logic        headVld, skidVld;
  logic        pop, push, pushCand, skidFullNxt;
  fetchEntry_t headEntry, pushEntry;

  assign pop       = headVld & ~id_stall;
  assign pushCand  = (state == WAIT) & imem_rvalid & ~discard;
  assign push      = pushCand & ~branch_taken;
  assign pushEntry = '{instr: imem_rdata, pc: pc};

  // Skid occupancy after this edge decides whether another request may issue.
  assign skidFullNxt = (skidVld & ~pop) | (pushCand & ((headVld & ~pop) | (skidVld & pop)));

  always_comb begin
    stateNxt   = state;
    pcNxt      = pc;
    discardNxt = discard;
    if (branch_taken) begin
      pcNxt      = wordAlign(branch_target);
      stateNxt   = FETCH;
      discardNxt = 1'b0;
      // A request still in flight after this edge belongs to the old stream.
      if ((state == FETCH) || ((state == WAIT) && !imem_rvalid)) begin
        stateNxt   = WAIT;
        discardNxt = 1'b1;
      end
    end else begin
      case (state)
        IDLE:  stateNxt = FETCH;
        FETCH: stateNxt = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discardNxt = 1'b0;
              stateNxt   = FETCH;
            end else begin
              pcNxt    = pc + 32'd4;
              stateNxt = skidFullNxt ? HOLD : FETCH;
            end
          end
        end
        HOLD: begin
          if (!skidFullNxt) stateNxt = FETCH;
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= stateNxt;
      pc        <= pcNxt;
      discard   <= discardNxt;
      imem_req  <= (stateNxt == FETCH);
      imem_addr <= (stateNxt == FETCH) ? pcNxt : '0;
    end
  end

  fetch_skid_buf uSkid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .flush     (branch_taken),
    .headVld   (headVld),
    .skidVld   (skidVld),
    .headEntry (headEntry)
  );

  assign instr_valid = headVld;
  assign instr       = headEntry.instr;
  assign pc_out      = headEntry.pc;
  assign opcode      = instr[31:26];

  alignedReq: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> (imem_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, stall/skid, redirects, PC wrap, reset mid-flight.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_rvalid, id_stall, branch_taken, instr_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_out;
  logic [5:0]  opcode;

  logic        req2, rvalid2, iv2, stall2, br2, pend2;
  logic [31:0] addr2, rdata2, tgt2, instr2, pc2;
  logic [5:0]  op2;

  int numChecks = 0;
  int numFails  = 0;
  int memLat    = 1;
  int strayCnt  = 0;
  int strayDone = 0;
  int reqCount  = 0;
  int cyc       = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t pendQ[$];
  logic [31:0] memImg [logic [31:0]];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_stall(id_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .opcode(opcode)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .id_stall(stall2),
    .branch_taken(br2), .branch_target(tgt2),
    .instr_valid(iv2), .instr(instr2), .pc_out(pc2), .opcode(op2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (memImg.exists(a)) return memImg[a];
    return {16'hE000, a[15:0]};
  endfunction

  // Memory model for the main instance: in-order, memLat cycles after the request.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (!rst_n) begin
        pendQ.delete();
      end else begin
        if (strayCnt != strayDone) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hDEAD_BEEF;
          strayDone++;
        end else if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memWord(pendQ[0].addr);
          void'(pendQ.pop_front());
        end
        if (imem_req) begin
          pendQ.push_back('{cyc + memLat, imem_addr});
          reqCount++;
        end
      end
    end
  end

  // One-cycle memory for the wrap instance.
  initial begin
    stall2 = 1'b0; br2 = 1'b0; tgt2 = '0;
    rvalid2 = 1'b0; rdata2 = '0; pend2 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rvalid2 = pend2;
      rdata2  = 32'h0123_4567;
      pend2   = req2 && rst_n;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    id_stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    repeat (2) tick();
  endtask

  task automatic waitReq(input logic [31:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 40) begin
      tick();
      n++;
    end
    checkVal("reqSeen", {31'd0, imem_req && (imem_addr == a)}, 32'd1);
  endtask

  initial begin
    int base;
    memImg[32'h0]   = 32'h8C22_0004;
    memImg[32'h4]   = 32'h1022_0003;
    memImg[32'h8]   = 32'h8C03_0000;
    memImg[32'h100] = 32'h00A4_2020;
    memImg[32'h200] = 32'hAC05_0010;

    // Reset values
    doReset();
    checkVal("rstReq", imem_req, 0);
    checkVal("rstAddr", imem_addr, 0);
    checkVal("rstValid", instr_valid, 0);
    checkVal("rstInstr", instr, 0);
    checkVal("rstPc", pc_out, 0);
    checkVal("rstOpcode", opcode, 0);

    // First fetch with 1-cycle memory; dut2 checks PC wrap alongside
    rst_n = 1'b1;
    tick();
    checkVal("c1Req", imem_req, 1);
    checkVal("c1Addr", imem_addr, 0);
    checkVal("wrapReq1", req2, 1);
    checkVal("wrapAddr1", addr2, 32'hFFFF_FFFC);
    tick();
    checkVal("c2Req", imem_req, 0);
    checkVal("c2Valid", instr_valid, 0);
    tick();
    checkVal("c3Valid", instr_valid, 1);
    checkVal("c3Instr", instr, 32'h8C22_0004);
    checkVal("c3Pc", pc_out, 0);
    checkVal("c3Opcode", opcode, 6'b100011);
    checkVal("c3Req", imem_req, 1);
    checkVal("c3Addr", imem_addr, 4);
    checkVal("wrapAddr2", addr2, 32'h0000_0000);
    checkVal("wrapPc", pc2, 32'hFFFF_FFFC);

    // Decode stall fills head and skid, then drains in order
    doReset();
    memImg[32'h0] = 32'hAC01_0008;
    id_stall = 1'b1;
    base = reqCount;
    rst_n = 1'b1;
    repeat (7) tick();
    checkVal("stallValid", instr_valid, 1);
    checkVal("stallInstr", instr, 32'hAC01_0008);
    checkVal("stallPc", pc_out, 0);
    checkVal("stallNoReq", imem_req, 0);
    checkVal("stallReqCount", reqCount - base, 2);
    id_stall = 1'b0;
    tick();
    checkVal("drain1Instr", instr, 32'h1022_0003);
    checkVal("drain1Pc", pc_out, 4);
    checkVal("resumeReq", imem_req, 1);
    checkVal("resumeAddr", imem_addr, 8);
    tick();
    checkVal("drain2Valid", instr_valid, 0);
    checkVal("drain2Instr", instr, 0);
    tick();
    checkVal("word8Valid", instr_valid, 1);
    checkVal("word8Pc", pc_out, 8);
    checkVal("word8Instr", instr, 32'h8C03_0000);

    // Redirect while the 0x10 request is outstanding (2-cycle memory)
    doReset();
    memLat = 2;
    rst_n = 1'b1;
    waitReq(32'h10);
    tick();
    checkVal("outstandingReq", imem_req, 0);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0102;
    tick();
    branch_taken = 1'b0;
    checkVal("dropValid", instr_valid, 0);
    checkVal("dropReq", imem_req, 0);
    tick();
    checkVal("tgtReq", imem_req, 1);
    checkVal("tgtAddr", imem_addr, 32'h100);
    checkVal("tgtEmpty0", instr_valid, 0);
    tick();
    checkVal("tgtEmpty1", instr_valid, 0);
    tick();
    checkVal("tgtEmpty2", instr_valid, 0);
    tick();
    checkVal("tgtValid", instr_valid, 1);
    checkVal("tgtPc", pc_out, 32'h100);
    checkVal("tgtInstr", instr, 32'h00A4_2020);
    checkVal("tgtOpcode", opcode, 6'b000000);

    // Redirect coinciding with a response and a pop
    doReset();
    memLat = 1;
    id_stall = 1'b1;
    rst_n = 1'b1;
    waitReq(32'h4);
    checkVal("preBrValid", instr_valid, 1);
    tick();
    id_stall = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    branch_taken = 1'b0;
    checkVal("brFlush", instr_valid, 0);
    checkVal("brReq", imem_req, 1);
    checkVal("brAddr", imem_addr, 32'h200);
    tick();
    checkVal("brEmpty", instr_valid, 0);
    tick();
    checkVal("brValid", instr_valid, 1);
    checkVal("brPc", pc_out, 32'h200);
    checkVal("brInstr", instr, 32'hAC05_0010);

    // Asynchronous reset while waiting with a valid head, stray response afterwards
    doReset();
    id_stall = 1'b1;
    rst_n = 1'b1;
    waitReq(32'h4);
    tick();
    checkVal("preRstValid", instr_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("asyncValid", instr_valid, 0);
    checkVal("asyncInstr", instr, 0);
    checkVal("asyncPc", pc_out, 0);
    checkVal("asyncOpcode", opcode, 0);
    checkVal("asyncReq", imem_req, 0);
    checkVal("asyncAddr", imem_addr, 0);
    tick();
    strayCnt++;
    rst_n = 1'b1;
    tick();
    checkVal("refetchReq", imem_req, 1);
    checkVal("refetchAddr", imem_addr, 0);
    checkVal("strayIgnored", instr_valid, 0);
    tick();
    checkVal("strayNotPushed", instr_valid, 0);
    tick();
    checkVal("refetchValid", instr_valid, 1);
    checkVal("refetchInstr", instr, 32'hAC01_0008);
    checkVal("refetchPc", pc_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
